ascon_block_packer: RTL and testbench

- Upstream feeder of the rate-XOR stage in the Ascon-128a datapath.
- Accepts 32-bit input words over a valid/ready stream and assembles them into 128-bit rate blocks.
- Applies Ascon 10* padding and emits each block over a valid/ready handshake. Tags every block as associated data or text, marks the final block, and reports its payload byte count for ciphertext truncation.

---
 rtl/ascon_block_packer.sv | 233 +++++++++++++++++++++++
 tb/tb_ascon_block_packer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_block_packer.sv
// ascon_block_packer
//   Packs 32-bit input words into 128-bit Ascon-128a rate blocks and applies
//   the 10* padding (PAD_BYTE, then zeros). Each block is tagged with its
//   stream type (AD or text), a final-block flag and its payload byte count.
//   When a stream ends exactly on a 16-byte boundary, a separate pad-only
//   block follows the full data block.
//
// Optional feature (macro ASCON_BLOCK_PACKER_CNT_EN):
//   adds blocks_cnt_o, a saturating count of emitted blocks.
//
// Ports:
//   clock_i        clock, rising edge
//   resetb_i       asynchronous active-low reset
//   data_i         input word, byte k = data_i[8k+7:8k]
//   data_valid_i   input word valid
//   data_last_i    word is last of the current AD/text stream
//   data_nbytes_i  valid bytes in a last word (1..4, others treated as 4)
//   data_type_i    0 = associated data, 1 = plaintext/ciphertext
//   data_ready_o   packer accepts a word this cycle
//   block_o        rate block, word w at block_o[32w+31:32w]
//   block_valid_o  block_o valid
//   block_ready_i  downstream consumes the block
//   block_last_o   block carries the padding
//   block_type_o   type of the block
//   block_nbytes_o payload bytes in the block, 0..16
//   blocks_cnt_o   emitted-block count (optional feature only)
module ascon_block_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h01
`ifdef ASCON_BLOCK_PACKER_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic [31:0]  data_i,
  input  logic         data_valid_i,
  input  logic         data_last_i,
  input  logic [2:0]   data_nbytes_i,
  input  logic         data_type_i,
  output logic         data_ready_o,
  output logic [127:0] block_o,
  output logic         block_valid_o,
  input  logic         block_ready_i,
  output logic         block_last_o,
  output logic         block_type_o,
  output logic [4:0]   block_nbytes_o
`ifdef ASCON_BLOCK_PACKER_CNT_EN
  , output logic [CNT_WIDTH-1:0] blocks_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [1:0]     widx_r, widx_s;
  logic [127:0]   block_r, block_s;
  logic           last_r, last_s;
  logic           type_r, type_s;
  logic [4:0]     nbytes_r, nbytes_s;
  logic           pad_r, pad_s;
  logic           valid_r, valid_s;
  logic           ready_r, ready_s;

  logic [2:0]     nb_s;
  logic [3:0]     be_s;
  logic [31:0]    word_s;
  logic [4:0]     total_s;

  // Effective byte count of the incoming word and its masked contents
  always_comb begin
    nb_s = 3'd4;
    if (data_last_i) begin
      case (data_nbytes_i)
        3'd1, 3'd2, 3'd3, 3'd4: nb_s = data_nbytes_i;
        default:                nb_s = 3'd4;
      endcase
    end else begin
      nb_s = 3'd4;
    end
    case (nb_s)
      3'd1:    be_s = 4'b0001;
      3'd2:    be_s = 4'b0011;
      3'd3:    be_s = 4'b0111;
      default: be_s = 4'b1111;
    endcase
    word_s = {be_s[3] ? data_i[31:24] : 8'h00,
              be_s[2] ? data_i[23:16] : 8'h00,
              be_s[1] ? data_i[15:8]  : 8'h00,
              be_s[0] ? data_i[7:0]   : 8'h00};
    // Payload length of the block if this word closes the stream
    total_s = {1'b0, widx_r, 2'b00} + {2'b00, nb_s};
  end

  // Next-state and next-output logic for the FILL/HOLD/PAD sequencer
  always_comb begin
    state_s  = state_r;
    widx_s   = widx_r;
    block_s  = block_r;
    last_s   = last_r;
    type_s   = type_r;
    nbytes_s = nbytes_r;
    pad_s    = pad_r;
    valid_s  = 1'b0;
    ready_s  = 1'b0;
    case (state_r)
      ST_FILL: begin
        // ready_r is low only in the first cycle after reset release
        if (data_valid_i && ready_r) begin
          block_s[{widx_r, 5'd0} +: 32] = word_s;
          if (widx_r == 2'd0) begin
            type_s = data_type_i;
          end else begin
            type_s = type_r;
          end
          if (data_last_i) begin
            state_s = ST_HOLD;
            widx_s  = 2'd0;
            valid_s = 1'b1;
            if (total_s < 5'd16) begin
              // Upper bytes are already zero: the block is cleared on each handshake
              block_s[{total_s[3:0], 3'b000} +: 8] = PAD_BYTE;
              last_s   = 1'b1;
              nbytes_s = total_s;
              pad_s    = 1'b0;
            end else begin
              last_s   = 1'b0;
              nbytes_s = 5'd16;
              pad_s    = 1'b1;
            end
          end else if (widx_r == 2'd3) begin
            state_s  = ST_HOLD;
            widx_s   = 2'd0;
            valid_s  = 1'b1;
            last_s   = 1'b0;
            nbytes_s = 5'd16;
            pad_s    = 1'b0;
          end else begin
            widx_s  = widx_r + 2'd1;
            ready_s = 1'b1;
          end
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (block_ready_i) begin
          if (pad_r) begin
            state_s = ST_PAD;
          end else begin
            state_s  = ST_FILL;
            block_s  = 128'd0;
            last_s   = 1'b0;
            nbytes_s = 5'd0;
            ready_s  = 1'b1;
          end
        end else begin
          valid_s = 1'b1;
        end
      end
      ST_PAD: begin
        block_s  = {120'd0, PAD_BYTE};
        last_s   = 1'b1;
        nbytes_s = 5'd0;
        pad_s    = 1'b0;
        valid_s  = 1'b1;
        state_s  = ST_HOLD;
      end
      default: begin
        state_s  = ST_FILL;
        widx_s   = 2'd0;
        block_s  = 128'd0;
        last_s   = 1'b0;
        nbytes_s = 5'd0;
        pad_s    = 1'b0;
        ready_s  = 1'b1;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_r  <= ST_FILL;
      widx_r   <= 2'd0;
      block_r  <= 128'd0;
      last_r   <= 1'b0;
      type_r   <= 1'b0;
      nbytes_r <= 5'd0;
      pad_r    <= 1'b0;
      valid_r  <= 1'b0;
      ready_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      widx_r   <= widx_s;
      block_r  <= block_s;
      last_r   <= last_s;
      type_r   <= type_s;
      nbytes_r <= nbytes_s;
      pad_r    <= pad_s;
      valid_r  <= valid_s;
      ready_r  <= ready_s;
    end
  end

  assign data_ready_o   = ready_r;
  assign block_o        = block_r;
  assign block_valid_o  = valid_r;
  assign block_last_o   = last_r;
  assign block_type_o   = type_r;
  assign block_nbytes_o = nbytes_r;

`ifdef ASCON_BLOCK_PACKER_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_r;

  // Saturating count of output handshakes, pad-only blocks included
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cnt_r <= '0;
    end else if (valid_r && block_ready_i && (cnt_r != '1)) begin
      cnt_r <= cnt_r + CNT_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign blocks_cnt_o = cnt_r;
`endif

endmodule

// File: tb/tb_ascon_block_packer.sv
// Self-checking bench for ascon_block_packer: table vectors, hand-written
// corner sequences (backpressure, mid-stream reset, pad latency) and random
// streams checked against a byte-level 10* padding model.
module tb_ascon_block_packer;

  logic         clock_i = 1'b0;
  logic         resetb_i = 1'b1;
  logic [31:0]  data_i = 32'd0;
  logic         data_valid_i = 1'b0;
  logic         data_last_i = 1'b0;
  logic [2:0]   data_nbytes_i = 3'd0;
  logic         data_type_i = 1'b0;
  logic         data_ready_o;
  logic [127:0] block_o;
  logic         block_valid_o;
  logic         block_ready_i;
  logic         block_last_o;
  logic         block_type_o;
  logic [4:0]   block_nbytes_o;
`ifdef ASCON_BLOCK_PACKER_CNT_EN
  logic [15:0]  blocks_cnt_o;
`endif

  ascon_block_packer dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_last_i(data_last_i),
    .data_nbytes_i(data_nbytes_i), .data_type_i(data_type_i),
    .data_ready_o(data_ready_o), .block_o(block_o),
    .block_valid_o(block_valid_o), .block_ready_i(block_ready_i),
    .block_last_o(block_last_o), .block_type_o(block_type_o),
    .block_nbytes_o(block_nbytes_o)
`ifdef ASCON_BLOCK_PACKER_CNT_EN
    , .blocks_cnt_o(blocks_cnt_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [127:0] blk;
    logic         last;
    logic         typ;
    logic [4:0]   nb;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] mb[$];
  int ready_mode = 1;

  // Downstream ready: 0 = stalled, 1 = always ready, other = random
  initial begin
    block_ready_i = 1'b0;
    forever begin
      @(posedge clock_i);
      #1;
      case (ready_mode)
        0:       block_ready_i = 1'b0;
        1:       block_ready_i = 1'b1;
        default: block_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard on handshake, stability while stalled
  logic         pend = 1'b0;
  logic [127:0] held_blk;
  logic [6:0]   held_attr;
  always @(negedge clock_i) begin
    if (!resetb_i) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        check("hold_valid", block_valid_o, 1'b1);
        check("hold_block", block_o, held_blk);
        check("hold_attr", {block_last_o, block_type_o, block_nbytes_o}, held_attr);
      end
      if (block_valid_o && block_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_block actual=%h required=none", block_o);
        end else begin
          check("blk_data", block_o, exp_q[0].blk);
          check("blk_last", block_last_o, exp_q[0].last);
          check("blk_type", block_type_o, exp_q[0].typ);
          check("blk_nbytes", block_nbytes_o, exp_q[0].nb);
          void'(exp_q.pop_front());
        end
        pend <= 1'b0;
      end else begin
        pend <= block_valid_o;
      end
      held_blk  <= block_o;
      held_attr <= {block_last_o, block_type_o, block_nbytes_o};
    end
  end

  task automatic send_word(input logic [31:0] w, input logic l, input logic [2:0] n, input logic t);
    int guard;
    bit done;
    data_i = w; data_last_i = l; data_nbytes_i = n; data_type_i = t; data_valid_i = 1'b1;
    guard = 0;
    done = 1'b0;
    while (!done && guard < 300) begin
      @(negedge clock_i);
      if (data_ready_o) done = 1'b1;
      else guard++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end else begin
      @(posedge clock_i);
    end
    #1;
    data_valid_i = 1'b0;
    data_last_i = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clock_i);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clock_i);
    #1;
  endtask

  // Reference: stream bytes, then 0x01, then zeros to a 16-byte multiple
  task automatic push_model(input int len, input logic t);
    int nblk;
    int rem;
    int idx;
    exp_t e;
    nblk = len / 16 + 1;
    for (int b = 0; b < nblk; b++) begin
      e.blk = 128'd0;
      for (int k = 0; k < 16; k++) begin
        idx = 16 * b + k;
        if (idx < len)       e.blk[8*k +: 8] = mb[idx];
        else if (idx == len) e.blk[8*k +: 8] = 8'h01;
        else                 e.blk[8*k +: 8] = 8'h00;
      end
      rem = len - 16 * b;
      e.nb = (rem >= 16) ? 5'd16 : 5'(rem);
      e.last = (b == nblk - 1);
      e.typ = t;
      exp_q.push_back(e);
    end
  endtask

  // Drives mb[0..len-1] as words; bytes past the end carry random junk
  task automatic send_model(input int len, input logic t, input bit gaps);
    int nw;
    int idx;
    logic [31:0] w;
    nw = (len + 3) / 4;
    for (int j = 0; j < nw; j++) begin
      for (int k = 0; k < 4; k++) begin
        idx = 4 * j + k;
        w[8*k +: 8] = (idx < len) ? mb[idx] : 8'($urandom);
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) @(posedge clock_i);
        #1;
      end
      send_word(w, j == nw - 1, 3'(len - 4 * (nw - 1)), t);
    end
  endtask

  typedef struct packed {
    logic [4:0][31:0]  w;
    logic [2:0]        nw;
    logic [2:0]        lastn;
    logic              typ;
    logic [1:0]        nblk;
    logic [1:0][127:0] eblk;
    logic [1:0]        elast;
    logic [1:0][4:0]   enb;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int i);
    exp_t e;
    for (int b = 0; b < int'(vecs[i].nblk); b++) begin
      e.blk = vecs[i].eblk[b];
      e.last = vecs[i].elast[b];
      e.typ = vecs[i].typ;
      e.nb = vecs[i].enb[b];
      exp_q.push_back(e);
    end
    for (int j = 0; j < int'(vecs[i].nw); j++) begin
      send_word(vecs[i].w[j], j == int'(vecs[i].nw) - 1, vecs[i].lastn, vecs[i].typ);
    end
    @(negedge clock_i);
    check("latency_valid", block_valid_o, 1'b1);
    if (vecs[i].nblk == 2'd2 && vecs[i].enb[1] == 5'd0) begin
      @(negedge clock_i);
      check("pad_gap_valid", block_valid_o, 1'b0);
      @(negedge clock_i);
      check("pad_valid", block_valid_o, 1'b1);
    end
    wait_drain();
  endtask

  logic [127:0] snap_blk;
  logic [6:0]   snap_attr;
  int           acc;
  int           len;
  logic         typ;

  initial begin
    vecs[0] = '0;
    vecs[0].w[0] = 32'h44332211; vecs[0].w[1] = 32'h00000055;
    vecs[0].nw = 3'd2; vecs[0].lastn = 3'd1; vecs[0].typ = 1'b0; vecs[0].nblk = 2'd1;
    vecs[0].eblk[0] = 128'h0000_0155_4433_2211; vecs[0].elast[0] = 1'b1; vecs[0].enb[0] = 5'd5;

    vecs[1] = '0;
    vecs[1].w[0] = 32'h03020100; vecs[1].w[1] = 32'h07060504;
    vecs[1].w[2] = 32'h0b0a0908; vecs[1].w[3] = 32'h0f0e0d0c;
    vecs[1].nw = 3'd4; vecs[1].lastn = 3'd4; vecs[1].typ = 1'b1; vecs[1].nblk = 2'd2;
    vecs[1].eblk[0] = 128'h0f0e0d0c_0b0a0908_07060504_03020100; vecs[1].elast[0] = 1'b0; vecs[1].enb[0] = 5'd16;
    vecs[1].eblk[1] = 128'h01; vecs[1].elast[1] = 1'b1; vecs[1].enb[1] = 5'd0;

    vecs[2] = '0;
    vecs[2].w[0] = 32'h13121110; vecs[2].w[1] = 32'h17161514;
    vecs[2].w[2] = 32'h1b1a1918; vecs[2].w[3] = 32'h1f1e1d1c; vecs[2].w[4] = 32'ha5a4a3a2;
    vecs[2].nw = 3'd5; vecs[2].lastn = 3'd4; vecs[2].typ = 1'b1; vecs[2].nblk = 2'd2;
    vecs[2].eblk[0] = 128'h1f1e1d1c_1b1a1918_17161514_13121110; vecs[2].elast[0] = 1'b0; vecs[2].enb[0] = 5'd16;
    vecs[2].eblk[1] = 128'h01_a5a4a3a2; vecs[2].elast[1] = 1'b1; vecs[2].enb[1] = 5'd4;

    vecs[3] = '0;
    vecs[3].w[0] = 32'hdeadbeef;
    vecs[3].nw = 3'd1; vecs[3].lastn = 3'd1; vecs[3].typ = 1'b0; vecs[3].nblk = 2'd1;
    vecs[3].eblk[0] = 128'h01ef; vecs[3].elast[0] = 1'b1; vecs[3].enb[0] = 5'd1;

    vecs[4] = '0;
    vecs[4].w[0] = 32'h33221100; vecs[4].w[1] = 32'h77665544; vecs[4].w[2] = 32'hbbaa9988;
    vecs[4].nw = 3'd3; vecs[4].lastn = 3'd4; vecs[4].typ = 1'b1; vecs[4].nblk = 2'd1;
    vecs[4].eblk[0] = 128'h00000001_bbaa9988_77665544_33221100; vecs[4].elast[0] = 1'b1; vecs[4].enb[0] = 5'd12;

    vecs[5] = '0;
    vecs[5].w[0] = 32'hcafef00d;
    vecs[5].nw = 3'd1; vecs[5].lastn = 3'd0; vecs[5].typ = 1'b0; vecs[5].nblk = 2'd1;
    vecs[5].eblk[0] = 128'h01_cafef00d; vecs[5].elast[0] = 1'b1; vecs[5].enb[0] = 5'd4;

    vecs[6] = '0;
    vecs[6].w[0] = 32'h04030201; vecs[6].w[1] = 32'haabbccdd;
    vecs[6].nw = 3'd2; vecs[6].lastn = 3'd3; vecs[6].typ = 1'b1; vecs[6].nblk = 2'd1;
    vecs[6].eblk[0] = 128'h01bbccdd_04030201; vecs[6].elast[0] = 1'b1; vecs[6].enb[0] = 5'd7;

    // Reset state
    #2 resetb_i = 1'b0;
    #1;
    check("rst_valid", block_valid_o, 1'b0);
    check("rst_block", block_o, 128'd0);
    check("rst_last", block_last_o, 1'b0);
    check("rst_type", block_type_o, 1'b0);
    check("rst_nbytes", block_nbytes_o, 5'd0);
    check("rst_ready", data_ready_o, 1'b0);
    #19 resetb_i = 1'b1;
    #1;
    check("ready_after_release", data_ready_o, 1'b0);
    @(posedge clock_i);
    #1;
    check("ready_one_cycle_later", data_ready_o, 1'b1);

    // Table vectors with an always-ready sink
    ready_mode = 1;
    for (int i = 0; i < 7; i++) run_vec(i);

    // Backpressure: 15-byte AD stream, sink stalled for 10 cycles
    ready_mode = 0;
    @(posedge clock_i);
    #1;
    mb.delete();
    for (int k = 0; k < 15; k++) mb.push_back(8'($urandom));
    push_model(15, 1'b0);
    send_model(15, 1'b0, 1'b0);
    @(negedge clock_i);
    check("bp_valid", block_valid_o, 1'b1);
    snap_blk = block_o;
    snap_attr = {block_last_o, block_type_o, block_nbytes_o};
    data_i = 32'h5a5a5a5a; data_last_i = 1'b0; data_type_i = 1'b0; data_valid_i = 1'b1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock_i);
      check("bp_block_stable", block_o, snap_blk);
      check("bp_attr_stable", {block_last_o, block_type_o, block_nbytes_o}, snap_attr);
      check("bp_ready_low", data_ready_o, 1'b0);
      if (data_valid_i && data_ready_o) acc++;
    end
    check("bp_accepted_words", acc, 0);
    data_valid_i = 1'b0;
    ready_mode = 1;
    wait_drain();

    // Reset after two accepted words discards them
    send_word(32'h99999999, 1'b0, 3'd4, 1'b1);
    send_word(32'h88888888, 1'b0, 3'd4, 1'b1);
    resetb_i = 1'b0;
    #1;
    check("mid_rst_valid", block_valid_o, 1'b0);
    check("mid_rst_block", block_o, 128'd0);
    check("mid_rst_attr", {block_last_o, block_type_o, block_nbytes_o}, 7'd0);
    check("mid_rst_ready", data_ready_o, 1'b0);
    @(negedge clock_i);
    resetb_i = 1'b1;
    @(posedge clock_i);
    #1;
    mb.delete();
    for (int k = 0; k < 16; k++) mb.push_back(8'(8'h60 + k));
    push_model(16, 1'b0);
    send_model(16, 1'b0, 1'b0);
    wait_drain();

    // Random streams, random gaps and random downstream ready
    ready_mode = 2;
    for (int s = 0; s < 30; s++) begin
      len = $urandom_range(1, 40);
      typ = 1'($urandom_range(0, 1));
      mb.delete();
      for (int k = 0; k < len; k++) mb.push_back(8'($urandom));
      push_model(len, typ);
      send_model(len, typ, 1'b1);
    end
    wait_drain();
    ready_mode = 1;

`ifdef ASCON_BLOCK_PACKER_CNT_EN
    resetb_i = 1'b0;
    #1;
    check("cnt_reset", blocks_cnt_o, 16'd0);
    @(negedge clock_i);
    resetb_i = 1'b1;
    @(posedge clock_i);
    #1;
    run_vec(1);
    run_vec(1);
    check("cnt_four", blocks_cnt_o, 16'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against a stuck run
  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
